rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one 8-input resource slot among 8 requesters.
- Outputs a one-hot grant vector and its 3-bit binary index, so the index drives the shared resource select directly.
- Adds an enable input, a rotating priority pointer, and a hold timeout so no single requester can starve the others.
- Sits between requesting agents and the shared datapath select.

---
 rtl/arb_pkg.sv | 13 +
 rtl/onehot8_to_idx.sv | 13 +
 rtl/rr_arbiter8.sv | 83 ++++++++
 tb/tb_rr_arbiter8.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/onehot8_to_idx.sv
// One-hot (or zero) 8-bit vector to 3-bit binary index.
module onehot8_to_idx
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] oh,
  output logic [IDX_W-1:0] idx
);

  assign idx[0] = oh[1] | oh[3] | oh[5] | oh[7];
  assign idx[1] = oh[2] | oh[3] | oh[6] | oh[7];
  assign idx[2] = oh[4] | oh[5] | oh[6] | oh[7];

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with enable and hold timeout.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_oh;
  logic [2*N_REQ-1:0] win_dbl;
  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               owner_req;

  // Rotate so ptr sits at bit 0, take lowest set bit, rotate back.
  assign req_dbl = {req, req} >> ptr;
  assign rot     = req_dbl[N_REQ-1:0];
  assign rot_oh  = rot & (~rot + 8'd1);
  assign win_dbl = {rot_oh, rot_oh} << ptr;
  assign win_oh  = win_dbl[2*N_REQ-1:N_REQ];

  onehot8_to_idx u_idx (
    .oh  (win_oh),
    .idx (win_idx)
  );

  assign owner_req = req[gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && |req) begin
            state     <= GRANT;
            gnt       <= win_oh;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (!owner_req || hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            hold_cnt  <= '0;
            timeout   <= owner_req;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized and directed check of rr_arbiter8 against a behavioural model.
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  // model state: owner=-1 means nobody holds the slot
  int m_owner = -1;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_to    = 0;

  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_idx   = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 0;
  endtask

  task automatic model_clock(input logic e, input logic [7:0] r);
    int i;
    m_to = 0;
    if (m_owner < 0) begin
      if (e && r != 0) begin
        for (int k = 0; k < 8; k++) begin
          i = (m_ptr + k) % 8;
          if (r[i]) begin
            m_owner = i;
            m_idx   = i;
            m_held  = 1;
            break;
          end
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (m_held == MAXH) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs();
    chk("gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("gnt_idx", int'(gnt_idx), m_idx);
    chk("gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
    chk("timeout", int'(timeout), m_to);
    chk("valid_eq_or", int'(gnt_valid), int'(|gnt));
    chk("onehot0", int'($onehot0(gnt)), 1);
  endtask

  task automatic step(input logic e, input logic [7:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    model_clock(e, r);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    model_reset();
    #1;
    check_outputs();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  int order[$];
  int prev_owner;
  int vcount;
  logic [7:0] r;

  initial begin
    // reset and single request
    do_reset();
    step(1'b1, 8'b0000_0100);
    chk("single_idx", int'(gnt_idx), 2);
    chk("single_gnt", int'(gnt), 8'h04);

    // round-robin rotation from ptr=0
    do_reset();
    prev_owner = -1;
    for (int c = 0; c < 40 && order.size() < 9; c++) begin
      r = (m_owner >= 0) ? (8'hFF & ~(8'(1) << m_owner)) : 8'hFF;
      step(1'b1, r);
      if (prev_owner < 0 && m_owner >= 0) order.push_back(int'(gnt_idx));
      prev_owner = m_owner;
    end
    chk("rot_count", order.size(), 9);
    foreach (order[k]) chk("rot_order", order[k], k % 8);

    // wrap-around: grant 5, release, then 6, then 0
    do_reset();
    step(1'b1, 8'h20);
    step(1'b1, 8'h00);
    step(1'b1, 8'h43);
    chk("wrap_first", int'(gnt_idx), 6);
    step(1'b1, 8'h03);
    step(1'b1, 8'h03);
    chk("wrap_second", int'(gnt_idx), 0);

    // timeout with requester 3 held
    do_reset();
    vcount = 0;
    for (int c = 0; c < MAXH; c++) begin
      step(1'b1, 8'h08);
      vcount += int'(gnt_valid);
    end
    chk("to_valid_cycles", vcount, MAXH);
    step(1'b1, 8'h08);
    chk("to_pulse", int'(timeout), 1);
    chk("to_revoked", int'(gnt_valid), 0);
    step(1'b1, 8'h08);
    chk("to_regrant", int'(gnt), 8'h08);
    chk("to_pulse_end", int'(timeout), 0);

    // enable gating
    do_reset();
    repeat (3) step(1'b0, 8'h10);
    chk("en_off", int'(gnt_valid), 0);
    step(1'b1, 8'h10);
    chk("en_on_idx", int'(gnt_idx), 4);
    step(1'b0, 8'h10);
    chk("en_drop_keep", int'(gnt), 8'h10);

    // async reset mid-grant
    do_reset();
    step(1'b1, 8'h80);
    chk("pre_rst_gnt", int'(gnt), 8'h80);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, 8'hFF);
    chk("post_rst_idx", int'(gnt_idx), 0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
      step(($urandom_range(0, 4) != 0), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
